// File: rtl/shift_sched_pkg.sv
// Shared definitions for the shift/rotate operation scheduler: state encoding
// and packed command field layout.
package shift_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_STEP      = 3'd2,
    S_WAIT_TICK = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  // Command is {auto, load, rotate, left, amt}. Flag positions are offsets
  // above the amt field, so the absolute bit is AMT_W + CMD_xxx.
  localparam int CMD_AMT_LSB = 0;
  localparam int CMD_LEFT    = 0;
  localparam int CMD_ROT     = 1;
  localparam int CMD_LOAD    = 2;
  localparam int CMD_AUTO    = 3;
  localparam int CMD_FLAGS   = 4;

  localparam int AMT_W_DFLT  = 4;
  localparam int CMD_W       = CMD_FLAGS + AMT_W_DFLT;

  function automatic int cmd_w(input int amt_w);
    return CMD_FLAGS + amt_w;
  endfunction

endpackage

// File: rtl/shift_op_scheduler_prescaler.sv
// Auto-mode burst prescaler: while enabled, emits a one-cycle tick after
// TICK_DIV-1 enabled cycles, then restarts from zero.
module tick_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 2);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/shift_op_scheduler.sv
// Two-requester arbiter and sequencer for the shared shift/rotate datapath.
// Define SHIFT_SCHED_FIXED_PRIO_EN for fixed priority (requester 0 wins).
module shift_op_scheduler
  import shift_sched_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int AMT_W    = 4,
  parameter int TICK_DIV = 50000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req,
  input  logic [AMT_W+3:0]      cmd0,
  input  logic [AMT_W+3:0]      cmd1,
  input  logic [DATA_W-1:0]     ld_val0,
  input  logic [DATA_W-1:0]     ld_val1,
  output logic [1:0]            gnt,
  output logic                  op_sel,
  output logic                  op_load,
  output logic [DATA_W-1:0]     op_data,
  output logic                  step_en,
  output logic                  op_rotate,
  output logic                  op_left,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = cmd_w(AMT_W);

  state_t            state;
  logic              lat_auto;
  logic [AMT_W-1:0]  lat_amt;
  logic [AMT_W-1:0]  cnt;
  logic [DATA_W-1:0] lat_val;
  logic              pick;
  logic [CW-1:0]     pick_cmd;
  logic [DATA_W-1:0] pick_val;
  logic              owner_req;
  logic              pre_en;
  logic              pre_clr;
  logic              tick;
`ifndef SHIFT_SCHED_FIXED_PRIO_EN
  logic              ptr;
`endif

  always_comb begin
`ifdef SHIFT_SCHED_FIXED_PRIO_EN
    pick = ~req[0];
`else
    pick = req[ptr] ? ptr : ~ptr;
`endif
    pick_cmd  = pick ? cmd1 : cmd0;
    pick_val  = pick ? ld_val1 : ld_val0;
    owner_req = req[op_sel];
    pre_en    = (state == S_WAIT_TICK);
    pre_clr   = !pre_en || !owner_req;
  end

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pre_en),
    .clr   (pre_clr),
    .tick  (tick)
  );

  // Outputs are registered; each state describes what happens at its exit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      gnt       <= '0;
      op_sel    <= 1'b0;
      op_load   <= 1'b0;
      op_data   <= '0;
      step_en   <= 1'b0;
      op_rotate <= 1'b0;
      op_left   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      lat_auto  <= 1'b0;
      lat_amt   <= '0;
      lat_val   <= '0;
      cnt       <= '0;
`ifndef SHIFT_SCHED_FIXED_PRIO_EN
      ptr       <= 1'b0;
`endif
    end else begin
      gnt     <= '0;
      op_load <= 1'b0;
      step_en <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req != 2'b00) begin
            gnt       <= pick ? 2'b10 : 2'b01;
            op_sel    <= pick;
            op_rotate <= pick_cmd[AMT_W+CMD_ROT];
            op_left   <= pick_cmd[AMT_W+CMD_LEFT];
            lat_auto  <= pick_cmd[AMT_W+CMD_AUTO];
            lat_amt   <= pick_cmd[CMD_AMT_LSB +: AMT_W];
            cnt       <= pick_cmd[CMD_AMT_LSB +: AMT_W];
            lat_val   <= pick_val;
            busy      <= 1'b1;
            state     <= pick_cmd[AMT_W+CMD_LOAD] ? S_LOAD : S_STEP;
          end
        end
        S_LOAD: begin
          op_load <= 1'b1;
          op_data <= lat_val;
          state   <= S_STEP;
        end
        S_STEP: begin
          // An auto burst leaves on its last step so the idle gap is exactly TICK_DIV-1.
          if (cnt != '0) begin
            step_en <= 1'b1;
            cnt     <= cnt - AMT_W'(1);
            if (cnt == AMT_W'(1) && lat_auto && owner_req) state <= S_WAIT_TICK;
          end else if (lat_auto && owner_req) begin
            state <= S_WAIT_TICK;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
`ifndef SHIFT_SCHED_FIXED_PRIO_EN
            ptr   <= ~op_sel;
`endif
          end
        end
        S_WAIT_TICK: begin
          if (!owner_req) begin
            done  <= 1'b1;
            state <= S_DONE;
`ifndef SHIFT_SCHED_FIXED_PRIO_EN
            ptr   <= ~op_sel;
`endif
          end else if (tick) begin
            cnt   <= lat_amt;
            state <= S_STEP;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
